// File: rtl/redmule_mx_beat_packer.sv
`timescale 1ns/1ps
// redmule_mx_beat_packer
// Packs MX groups (NUM_LANES elements + one shared exponent) coming from the
// MX encoder into full DATA_W beats for the memory streamer. A group flagged
// last closes the beat early; unused slots of a partial beat read as zero.
//
// Ports
//   clk_i, rst_i     clock, asynchronous active-high reset
//   mx_valid_i/mx_ready_o, mx_data_i, mx_exp_i, mx_last_i   input group stream
//   out_valid_o/out_ready_i, out_data_o, out_exp_o,
//   out_count_o, out_last_o                                packed beat stream
//
// Two storage stages: a fill buffer being assembled and an output register.
// While the output register is stalled, the fill buffer can still complete
// a beat, so up to 2*GROUPS groups are held before mx_ready_o drops.
module redmule_mx_beat_packer #(
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned ELEM_W    = 8,
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned EXP_W     = 8,
  localparam int unsigned GRP_W    = NUM_LANES * ELEM_W,
  localparam int unsigned GROUPS   = DATA_W / GRP_W,
  localparam int unsigned CNT_W    = $clog2(GROUPS + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    mx_valid_i,
  output logic                    mx_ready_o,
  input  logic [GRP_W-1:0]        mx_data_i,
  input  logic [EXP_W-1:0]        mx_exp_i,
  input  logic                    mx_last_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [DATA_W-1:0]       out_data_o,
  output logic [GROUPS*EXP_W-1:0] out_exp_o,
  output logic [CNT_W-1:0]        out_count_o,
  output logic                    out_last_o
);

  localparam int unsigned SLOT_W = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  if ((DATA_W % GRP_W) != 0 || GROUPS < 1) begin : g_bad_cfg
    $error("redmule_mx_beat_packer: DATA_W must be a nonzero multiple of NUM_LANES*ELEM_W");
  end

  logic [DATA_W-1:0]       fill_data_q, fill_data_d;
  logic [GROUPS*EXP_W-1:0] fill_exp_q,  fill_exp_d;
  logic [CNT_W-1:0]        fill_cnt_q,  fill_cnt_d;
  logic                    fill_last_q, fill_last_d;
  logic                    fill_done_q, fill_done_d;

  logic                    out_free;
  logic                    mv;
  logic                    acc;
  logic [SLOT_W-1:0]       slot;

  // out_free is the only path from out_ready_i to mx_ready_o
  assign out_free   = !out_valid_o | out_ready_i;
  assign mv         = fill_done_q & out_free;
  assign mx_ready_o = !fill_done_q | out_free;
  assign acc        = mx_valid_i & mx_ready_o;

  always_comb begin
    fill_data_d = fill_data_q;
    fill_exp_d  = fill_exp_q;
    fill_cnt_d  = fill_cnt_q;
    fill_last_d = fill_last_q;
    fill_done_d = fill_done_q;
    slot        = '0;

    // A move empties the fill buffer first, so a group accepted in the same
    // cycle starts the next beat at slot 0.
    if (mv) begin
      fill_data_d = '0;
      fill_exp_d  = '0;
      fill_cnt_d  = '0;
      fill_last_d = 1'b0;
      fill_done_d = 1'b0;
    end

    if (acc) begin
      slot = fill_cnt_d[SLOT_W-1:0];
      fill_data_d[slot*GRP_W +: GRP_W] = mx_data_i;
      fill_exp_d[slot*EXP_W +: EXP_W]  = mx_exp_i;
      fill_cnt_d  = fill_cnt_d + CNT_W'(1);
      fill_last_d = mx_last_i;
      fill_done_d = mx_last_i | (fill_cnt_d == CNT_W'(GROUPS));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fill_data_q <= '0;
      fill_exp_q  <= '0;
      fill_cnt_q  <= '0;
      fill_last_q <= 1'b0;
      fill_done_q <= 1'b0;
    end else begin
      fill_data_q <= fill_data_d;
      fill_exp_q  <= fill_exp_d;
      fill_cnt_q  <= fill_cnt_d;
      fill_last_q <= fill_last_d;
      fill_done_q <= fill_done_d;
    end
  end

  // Contents are only reloaded on a move, which keeps out_* frozen while
  // the consumer stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_exp_o   <= '0;
      out_count_o <= '0;
      out_last_o  <= 1'b0;
    end else if (mv) begin
      out_valid_o <= 1'b1;
      out_data_o  <= fill_data_q;
      out_exp_o   <= fill_exp_q;
      out_count_o <= fill_cnt_q;
      out_last_o  <= fill_last_q;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_redmule_mx_beat_packer.sv
`timescale 1ns/1ps
module tb_redmule_mx_beat_packer;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         mx_valid_i = 1'b0;
  logic         mx_ready_o;
  logic [31:0]  mx_data_i = '0;
  logic [7:0]   mx_exp_i = '0;
  logic         mx_last_i = 1'b0;
  logic         out_valid_o;
  logic         out_ready_i = 1'b0;
  logic [255:0] out_data_o;
  logic [63:0]  out_exp_o;
  logic [3:0]   out_count_o;
  logic         out_last_o;

  redmule_mx_beat_packer dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .mx_valid_i  (mx_valid_i),
    .mx_ready_o  (mx_ready_o),
    .mx_data_i   (mx_data_i),
    .mx_exp_i    (mx_exp_i),
    .mx_last_i   (mx_last_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_exp_o   (out_exp_o),
    .out_count_o (out_count_o),
    .out_last_o  (out_last_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [255:0] d;
    logic [63:0]  e;
    logic [3:0]   c;
    logic         l;
  } beat_t;

  int checks = 0;
  int failures = 0;

  beat_t       exp_q[$];
  logic [31:0] pend_d[$];
  logic [7:0]  pend_e[$];

  logic         stall_prev = 1'b0;
  logic [325:0] snap_prev = '0;
  logic         watch_ready = 1'b0;
  int           ready_drops = 0;

  task automatic chk(input string nm, input logic [329:0] act, input logic [329:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: groups accumulate in arrival order; a beat is closed after
  // eight groups or at a last group, with absent slots reading zero.
  task automatic model_accept(input logic [31:0] d, input logic [7:0] e, input logic l);
    beat_t b;
    pend_d.push_back(d);
    pend_e.push_back(e);
    if (pend_d.size() == 8 || l) begin
      b.d = '0;
      b.e = '0;
      b.c = 4'(pend_d.size());
      b.l = l;
      for (int g = 0; g < pend_d.size(); g++) begin
        b.d[g*32 +: 32] = pend_d[g];
        b.e[g*8 +: 8]   = pend_e[g];
      end
      exp_q.push_back(b);
      pend_d.delete();
      pend_e.delete();
    end
  endtask

  // Monitor: everything sampled at the falling edge reflects what the next
  // rising edge will see.
  always @(negedge clk_i) begin
    beat_t b;
    if (rst_i) begin
      pend_d.delete();
      pend_e.delete();
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        chk("stall_stable", 330'({out_valid_o, out_last_o, out_count_o, out_exp_o, out_data_o}),
            330'(snap_prev));
      stall_prev = out_valid_o && !out_ready_i;
      snap_prev  = {out_valid_o, out_last_o, out_count_o, out_exp_o, out_data_o};
      if (watch_ready && !mx_ready_o) ready_drops++;
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 330'(1), 330'(0));
        end else begin
          b = exp_q.pop_front();
          chk("beat_data",  330'(out_data_o),  330'(b.d));
          chk("beat_exp",   330'(out_exp_o),   330'(b.e));
          chk("beat_count", 330'(out_count_o), 330'(b.c));
          chk("beat_last",  330'(out_last_o),  330'(b.l));
        end
      end
      if (mx_valid_i && mx_ready_o) model_accept(mx_data_i, mx_exp_i, mx_last_i);
    end
  end

  task automatic send_group(input logic [31:0] d, input logic [7:0] e, input logic l);
    logic took;
    took = 1'b0;
    mx_valid_i = 1'b1;
    mx_data_i  = d;
    mx_exp_i   = e;
    mx_last_i  = l;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      took = mx_ready_o;
      @(posedge clk_i);
      #1;
      if (took) break;
    end
    if (!took) chk("send_timeout", 330'(0), 330'(1));
  endtask

  task automatic drain();
    mx_valid_i  = 1'b0;
    mx_last_i   = 1'b0;
    out_ready_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() == 0 && !out_valid_o) break;
    end
    chk("drain_empty", 330'(exp_q.size() == 0 && !out_valid_o), 330'(1));
  endtask

  function automatic logic [31:0] kdata(input int k);
    logic [7:0] kb;
    kb = 8'(k);
    return {4{kb}};
  endfunction

  initial begin
    int   idx;
    logic took;

    // 1: reset held with valid asserted
    rst_i = 1'b1;
    mx_valid_i = 1'b1;
    mx_data_i = 32'hdeadbeef;
    repeat (3) begin
      @(negedge clk_i);
      chk("rst_valid", 330'(out_valid_o), 330'(0));
      chk("rst_outs", 330'({out_data_o, out_exp_o, out_count_o, out_last_o}), 330'(0));
    end
    @(posedge clk_i);
    #1;
    mx_valid_i = 1'b0;
    rst_i = 1'b0;
    #1;
    chk("ready_after_rst", 330'(mx_ready_o), 330'(1));

    // 2: streaming, 16 groups back-to-back
    out_ready_i = 1'b1;
    watch_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      send_group(kdata(k), 8'(8'h70 + k), 1'b0);
      if (k == 7) chk("lat_not_yet", 330'(out_valid_o), 330'(0));
      if (k == 8) begin
        chk("lat_valid", 330'(out_valid_o), 330'(1));
        chk("beat0_exp", 330'(out_exp_o), 330'(64'h7776757473727170));
        chk("beat0_count", 330'(out_count_o), 330'(8));
      end
    end
    watch_ready = 1'b0;
    drain();
    chk("ready_never_dropped", 330'(ready_drops), 330'(0));

    // 3: partial flush
    send_group(32'ha1a2a3a4, 8'h11, 1'b0);
    send_group(32'hb1b2b3b4, 8'h22, 1'b0);
    send_group(32'hc1c2c3c4, 8'h33, 1'b1);
    mx_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("partial_valid", 330'(out_valid_o), 330'(1));
    chk("partial_count", 330'(out_count_o), 330'(3));
    chk("partial_last", 330'(out_last_o), 330'(1));
    chk("partial_hi_data", 330'(out_data_o[255:96]), 330'(0));
    chk("partial_hi_exp", 330'(out_exp_o[63:24]), 330'(0));
    drain();

    // 4 + 5: backpressure, then release with a group offered
    out_ready_i = 1'b0;
    idx = 0;
    for (int c = 0; c < 30; c++) begin
      mx_valid_i = 1'b1;
      mx_data_i  = 32'h5000_0000 + 32'(idx);
      mx_exp_i   = 8'(idx);
      mx_last_i  = 1'b0;
      @(negedge clk_i);
      took = mx_ready_o;
      @(posedge clk_i);
      #1;
      if (took) idx++;
    end
    chk("bp_accepted", 330'(idx), 330'(16));
    chk("bp_ready_low", 330'(mx_ready_o), 330'(0));
    out_ready_i = 1'b1;
    #1;
    chk("sim_ready_comb", 330'(mx_ready_o), 330'(1));
    @(posedge clk_i);
    #1;
    chk("sim_fill_cnt", 330'(dut.fill_cnt_q), 330'(1));
    for (int k = 17; k < 20; k++)
      send_group(32'h5000_0000 + 32'(k), 8'(k), k == 19);
    drain();

    // 6: async reset with a stalled beat and a partial fill pending
    out_ready_i = 1'b0;
    for (int k = 0; k < 13; k++) send_group(32'h6000_0000 + 32'(k), 8'(k), 1'b0);
    mx_valid_i = 1'b0;
    chk("pre_rst_valid", 330'(out_valid_o), 330'(1));
    #2;
    rst_i = 1'b1;
    #1;
    chk("midrst_valid", 330'(out_valid_o), 330'(0));
    chk("midrst_outs", 330'({out_data_o, out_exp_o, out_count_o, out_last_o}), 330'(0));
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    out_ready_i = 1'b1;
    send_group(32'h7777_0001, 8'h81, 1'b0);
    send_group(32'h7777_0002, 8'h82, 1'b0);
    send_group(32'h7777_0003, 8'h83, 1'b1);
    drain();

    // randomized traffic with random backpressure
    mx_valid_i = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk_i);
      took = mx_valid_i && mx_ready_o;
      @(posedge clk_i);
      #1;
      if (!mx_valid_i || took) begin
        mx_valid_i = ($urandom_range(0, 3) != 0);
        mx_data_i  = $urandom;
        mx_exp_i   = 8'($urandom);
        mx_last_i  = ($urandom_range(0, 5) == 0);
      end
      out_ready_i = ($urandom_range(0, 3) != 0);
    end
    send_group($urandom, 8'($urandom), 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
